// File: rtl/shift_pkg.sv
// Shared definitions for shift/serdes style blocks: command encodings and
// the width helper for bit counters that must reach the register width.
package shift_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_ROL   = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_RSVD  = 3'b111
  } shift_mode_e;

  // Bits needed to represent 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_cell.sv
// One bit of the universal shift register: next-state mux plus flop.
// Boundary bits receive their serial or wrap-around source through the neighbour inputs.
module shift_cell
  import shift_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  shift_mode_e mode,
  input  logic        left_bit,
  input  logic        right_bit,
  input  logic        pin_bit,
  input  logic        rst_bit,
  output logic        q
);

  logic q_next;

  always_comb begin
    q_next = q;
    if (en) begin
      unique case (mode)
        MODE_SHL, MODE_ROL: q_next = right_bit;
        MODE_SHR, MODE_ROR: q_next = left_bit;
        MODE_LOAD:          q_next = pin_bit;
        MODE_CLEAR:         q_next = rst_bit;
        default:            q_next = q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= rst_bit;
    else      q <= q_next;
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: shift/rotate/load/clear with a shift counter that
// pulses frame_done for one cycle each time WIDTH shift operations complete.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [2:0]                  mode,
  input  logic [WIDTH-1:0]            pin,
  input  logic                        sin_l,
  input  logic                        sin_r,
  output logic [WIDTH-1:0]            pout,
  output logic                        sout_l,
  output logic                        sout_r,
  output logic [cnt_width(WIDTH)-1:0] bit_cnt,
  output logic                        frame_done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  shift_mode_e mode_e;
  assign mode_e = shift_mode_e'(mode);

  // The end cells pick serial input or the opposite end depending on shift vs rotate.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic l_nb;
    logic r_nb;

    if (i == WIDTH - 1) begin : g_msb
      assign l_nb = (mode_e == MODE_ROR) ? pout[0] : sin_l;
    end else begin : g_mid_l
      assign l_nb = pout[i+1];
    end

    if (i == 0) begin : g_lsb
      assign r_nb = (mode_e == MODE_ROL) ? pout[WIDTH-1] : sin_r;
    end else begin : g_mid_r
      assign r_nb = pout[i-1];
    end

    shift_cell u_cell (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .mode      (mode_e),
      .left_bit  (l_nb),
      .right_bit (r_nb),
      .pin_bit   (pin[i]),
      .rst_bit   (RST_VAL[i]),
      .q         (pout[i])
    );
  end

  assign sout_l = pout[WIDTH-1];
  assign sout_r = pout[0];

  logic            is_shift;
  logic [CW-1:0]   cnt_next;
  logic            done_next;

  assign is_shift = (mode_e == MODE_SHL) || (mode_e == MODE_SHR) ||
                    (mode_e == MODE_ROL) || (mode_e == MODE_ROR);

  // frame_done defaults low so it can only ever be a single-cycle pulse.
  always_comb begin
    cnt_next  = bit_cnt;
    done_next = 1'b0;
    if (en) begin
      if (is_shift) begin
        if (bit_cnt == LAST_CNT) begin
          cnt_next  = '0;
          done_next = 1'b1;
        end else begin
          cnt_next = bit_cnt + 1'b1;
        end
      end else if (mode_e == MODE_LOAD || mode_e == MODE_CLEAR) begin
        cnt_next = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      bit_cnt    <= cnt_next;
      frame_done <= done_next;
    end
  end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 4, meaning register width in bits; legal range 2..64.
REQ-002 Parameter RST_VAL, default all-zero (WIDTH bits), meaning register contents after reset and after a CLEAR command.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port en, input, 1 bit: command qualifier; when low, all state holds.
REQ-006 Port mode, input, 3 bits: command select per REQ-011.
REQ-007 Port pin, input, WIDTH bits: parallel load data.
REQ-008 Port sin_l, input, 1 bit: serial input entering the MSB on right-shift.
REQ-009 Port sin_r, input, 1 bit: serial input entering the LSB on left-shift.
REQ-010 Outputs: pout (WIDTH, register contents); sout_l (1, equals pout[WIDTH-1]); sout_r (1, equals pout[0]); bit_cnt (clog2(WIDTH+1), shift-op counter); frame_done (1, one-cycle pulse).

Function
REQ-011 mode encoding SHALL be: 000 HOLD; 001 SHL; 010 SHR; 011 ROL; 100 ROR; 101 LOAD; 110 CLEAR; 111 HOLD (reserved).
REQ-012 SHL: pout <= {pout[WIDTH-2:0], sin_r}. SHR: pout <= {sin_l, pout[WIDTH-1:1]}.
REQ-013 ROL: pout <= {pout[WIDTH-2:0], pout[WIDTH-1]}. ROR: pout <= {pout[0], pout[WIDTH-1:1]}.
REQ-014 LOAD: pout <= pin, latency one clock, all bits simultaneously.
REQ-015 CLEAR: pout <= RST_VAL, bit_cnt <= 0, frame_done <= 0.
REQ-016 sout_l and sout_r SHALL be combinational taps of pout (no added latency).
REQ-017 bit_cnt SHALL increment by 1 on each enabled SHL/SHR/ROL/ROR and SHALL reset to 0 on LOAD or CLEAR.
REQ-018 When an enabled shift/rotate occurs with bit_cnt == WIDTH-1, bit_cnt SHALL wrap to 0 and frame_done SHALL be 1 in the following cycle only.
REQ-019 frame_done SHALL be a registered output, 0 in every cycle not covered by REQ-018.
REQ-020 With en low, pout, bit_cnt and frame_done SHALL hold, except that frame_done SHALL still drop to 0 after its single-cycle pulse.
REQ-021 HOLD and the reserved code SHALL leave pout and bit_cnt unchanged; frame_done SHALL be 0.
REQ-022 Mixed shift directions SHALL all count toward the same bit_cnt; the direction is not tracked.
REQ-023 Any change of mode takes effect on the next enabled edge; no idle cycle is required between commands.

Reset
REQ-024 When rst is low: pout = RST_VAL, bit_cnt = 0, frame_done = 0, immediately and independent of clk.
REQ-025 Reset asserted mid-frame SHALL discard partial bit_cnt; no frame_done is generated for the aborted frame.
REQ-026 After rst deasserts, the first rising clk edge SHALL execute the presented command normally.

Structure
REQ-027 Mode encodings and the counter-width function SHALL live in shared package shift_pkg, for reuse by future shift/serdes blocks.
REQ-028 Per-bit next-state mux plus flop SHALL be sub-module shift_cell (inputs: own bit, left/right neighbour, pin bit, RST_VAL bit, mode, en; async active-low reset), instantiated WIDTH times via generate.
REQ-029 Counter and frame_done logic SHALL reside in univ_shift_reg top level.

Verification (WIDTH=4, RST_VAL=0)
REQ-030 LOAD pin=1011, then HOLD 3 cycles -> pout=1011 throughout, bit_cnt=0, frame_done=0.
REQ-031 LOAD 1011, SHL with sin_r=0,1,1,0 -> pout=0110,1101,1011,0110; frame_done=1 only in the cycle after the 4th shift; bit_cnt=0 after wrap.
REQ-032 LOAD 1000, ROR x4 -> pout=0100,0010,0001,1000; sout_r=0,0,1,0; one frame_done pulse.
REQ-033 LOAD 1111, SHR x2 (sin_l=0), then en low 3 cycles, then SHR x2 -> pout 0011 held during idle; frame_done after the 4th enabled shift only.
REQ-034 LOAD 0101, ROL x2, rst low asynchronously mid-cycle -> pout=0000 and bit_cnt=0 before next clk edge; 2 further ROLs produce no frame_done.
REQ-035 CLEAR issued when bit_cnt=3 -> pout=0000, bit_cnt=0, no frame_done.
